clk_div_sched: RTL and testbench

//  Shares one free-running power-of-two clock divider among N_REQ requesters.

---
 rtl/clk_div_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 26 ++
 rtl/clk_div_sched.sv | 162 ++++++++++++++++
 tb/tb_clk_div_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider scheduler: FSM state encoding,
// default widths and the round-robin pick function used by the arbiter.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    OWN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_TAP_W = 2;
  localparam int MAX_REQ   = 32;

  // Index of the first set request at or after ptr, wrapping at n; 0 if none.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int n, input int ptr);
    int idx;
    rr_pick = 0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request starting at ptr,
// returned both as an index and as a one-hot vector.
module rr_arbiter
  import clk_div_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             valid
);

  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    winner_idx           = IDX_W'(rr_pick(req_ext, N_REQ, int'(ptr)));
    valid                = |req;
    winner               = valid ? (N_REQ'(1) << winner_idx) : '0;
  end

endmodule

// File: rtl/clk_div_sched.sv
// Shared power-of-two clock divider with round-robin ownership. Owner and tap
// only change on counter wrap, so div_clk never produces a truncated pulse.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TAP_W    = DEF_TAP_W,
  parameter int MAX_HOLD = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*TAP_W-1:0] tap_sel,
  output logic [N_REQ-1:0]       gnt,
  output logic                   div_clk,
  output logic                   div_en,
  output logic [TAP_W-1:0]       active_tap,
  output logic                   busy
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [TAP_W-1:0]   pend_tap_q, pend_tap_d;
  logic [TAP_W-1:0]   active_tap_q, active_tap_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               div_clk_q, div_clk_d;
  logic               div_en_q, div_en_d;

  logic [N_REQ-1:0]   arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [TAP_W-1:0]   arb_tap;
  logic               wrap;
  logic               others_pending;
  logic               take_arb;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req),
    .ptr        (rr_ptr_q),
    .winner     (arb_onehot),
    .winner_idx (arb_idx),
    .valid      (arb_valid)
  );

  assign arb_tap        = tap_sel[arb_idx*TAP_W +: TAP_W];
  assign wrap           = &cnt_q;
  assign others_pending = |(req & ~gnt_q);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    owner_d      = owner_q;
    pend_tap_d   = pend_tap_q;
    active_tap_d = active_tap_q;
    rr_ptr_d     = rr_ptr_q;
    hold_d       = hold_q;
    gnt_d        = gnt_q;
    take_arb     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d    = PEND;
          owner_d    = arb_idx;
          pend_tap_d = arb_tap;
        end
      end
      PEND: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d      = OWN;
          gnt_d        = N_REQ'(1) << owner_q;
          active_tap_d = pend_tap_q;
          hold_d       = '0;
          rr_ptr_d     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end
      end
      OWN: begin
        if (wrap) begin
          if (!req[owner_q] || (hold_q == HOLD_MAX && others_pending)) begin
            take_arb = 1'b1;
          end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end
        end else if (!req[owner_q]) begin
          // Grant drops now, but the current tap keeps running until the wrap.
          state_d = DRAIN;
          gnt_d   = '0;
        end
      end
      DRAIN: begin
        if (wrap) take_arb = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (take_arb) begin
      if (arb_valid) begin
        state_d      = OWN;
        owner_d      = arb_idx;
        gnt_d        = arb_onehot;
        active_tap_d = arb_tap;
        hold_d       = '0;
        rr_ptr_d     = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end

    div_clk_d = (state_d == OWN || state_d == DRAIN) ? cnt_d[active_tap_d] : 1'b0;
    div_en_d  = div_clk_d & ~div_clk_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= '0;
      pend_tap_q   <= '0;
      active_tap_q <= '0;
      rr_ptr_q     <= '0;
      hold_q       <= '0;
      gnt_q        <= '0;
      div_clk_q    <= 1'b0;
      div_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      pend_tap_q   <= pend_tap_d;
      active_tap_q <= active_tap_d;
      rr_ptr_q     <= rr_ptr_d;
      hold_q       <= hold_d;
      gnt_q        <= gnt_d;
      div_clk_q    <= div_clk_d;
      div_en_q     <= div_en_d;
    end
  end

  assign gnt        = gnt_q;
  assign div_clk    = div_clk_q;
  assign div_en     = div_en_q;
  assign active_tap = active_tap_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: table of single-grant vectors from reset,
// hand-written sequences for hold/handover, drain, tap freeze, reset and release+request.
module tb_clk_div_sched;

  localparam int N_REQ    = 4;
  localparam int CNT_W    = 4;
  localparam int TAP_W    = 2;
  localparam int MAX_HOLD = 2;

  logic                   CLK = 1'b0;
  logic                   RESET;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*TAP_W-1:0] tap_sel;
  logic [N_REQ-1:0]       gnt;
  logic                   div_clk;
  logic                   div_en;
  logic [TAP_W-1:0]       active_tap;
  logic                   busy;

  clk_div_sched #(
    .N_REQ    (N_REQ),
    .CNT_W    (CNT_W),
    .TAP_W    (TAP_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req        (req),
    .tap_sel    (tap_sel),
    .gnt        (gnt),
    .div_clk    (div_clk),
    .div_en     (div_en),
    .active_tap (active_tap),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Reference free-running counter: the value the divider counter should hold each cycle.
  logic [CNT_W-1:0] tb_cnt;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) tb_cnt <= '0;
    else       tb_cnt <= tb_cnt + 1'b1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N_REQ-1:0] gnt;
    logic [TAP_W-1:0] tap;
    int               lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [N_REQ-1:0]       req;
    logic [N_REQ*TAP_W-1:0] tap_sel;
    logic [CNT_W-1:0]       start_cnt;
    logic [N_REQ-1:0]       exp_gnt;
    logic [TAP_W-1:0]       exp_tap;
    int                     exp_lat;
  } vec_t;
  vec_t vecs[5];

  task automatic do_reset();
    @(negedge CLK);
    RESET   = 1'b1;
    req     = '0;
    tap_sel = '0;
    @(negedge CLK);
    check("reset_outputs", {gnt, div_clk, div_en, active_tap, busy}, '0);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic wait_cnt(input logic [CNT_W-1:0] c);
    int n = 0;
    while (tb_cnt != c && n < 40) begin
      @(negedge CLK);
      n++;
    end
  endtask

  // Counts clock edges from the drive point until a grant appears (bounded).
  task automatic wait_grant(output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (gnt == '0 && lat < 40);
  endtask

  task automatic wait_change(input logic [N_REQ-1:0] prev, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (gnt == prev && n < 100);
  endtask

  task automatic sb_check(input string name, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = sb.pop_front();
    check({name, "_gnt"}, gnt, e.gnt);
    check({name, "_tap"}, active_tap, e.tap);
    check({name, "_lat"}, lat, e.lat);
  endtask

  // Waveform monitor: div_en coincides with rises; high and low runs match the tap.
  initial begin
    logic       prev_clk = 1'b0;
    int         run_len  = 0;
    logic [1:0] run_tap  = '0;
    logic       low_ok   = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        prev_clk = 1'b0;
        run_len  = 0;
        low_ok   = 1'b0;
      end else begin
        check("div_en_pulse", div_en, div_clk & ~prev_clk);
        if (div_clk && !prev_clk) begin
          if (low_ok) check("low_len", run_len, 1 << active_tap);
          run_len = 1;
          run_tap = active_tap;
        end else if (!div_clk && prev_clk) begin
          check("high_len", run_len, 1 << run_tap);
          run_len = 1;
          low_ok  = 1'b1;
        end else begin
          run_len++;
        end
        if (!busy) low_ok = 1'b0;
        prev_clk = div_clk;
      end
    end
  end

  initial begin
    int lat;
    int n;

    RESET   = 1'b1;
    req     = '0;
    tap_sel = '0;

    vecs[0] = '{req: 4'b0100, tap_sel: 8'h10, start_cnt: 4'd5,  exp_gnt: 4'b0100, exp_tap: 2'd1, exp_lat: 11};
    vecs[1] = '{req: 4'b0011, tap_sel: 8'h0E, start_cnt: 4'd0,  exp_gnt: 4'b0001, exp_tap: 2'd2, exp_lat: 16};
    vecs[2] = '{req: 4'b1000, tap_sel: 8'hC0, start_cnt: 4'd15, exp_gnt: 4'b1000, exp_tap: 2'd3, exp_lat: 17};
    vecs[3] = '{req: 4'b1010, tap_sel: 8'h40, start_cnt: 4'd9,  exp_gnt: 4'b0010, exp_tap: 2'd0, exp_lat: 7};
    vecs[4] = '{req: 4'b1111, tap_sel: 8'hE4, start_cnt: 4'd3,  exp_gnt: 4'b0001, exp_tap: 2'd0, exp_lat: 13};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      wait_cnt(vecs[i].start_cnt);
      req     = vecs[i].req;
      tap_sel = vecs[i].tap_sel;
      sb.push_back('{gnt: vecs[i].exp_gnt, tap: vecs[i].exp_tap, lat: vecs[i].exp_lat});
      wait_grant(lat);
      sb_check($sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d_busy", i), busy, 1'b1);
      repeat (12) @(negedge CLK);
    end

    // Two held requesters: owner keeps the divider for MAX_HOLD+1 periods, then hands over without a gap.
    do_reset();
    req     = 4'b0011;
    tap_sel = 8'h04;
    sb.push_back('{gnt: 4'b0001, tap: 2'd0, lat: 16});
    sb.push_back('{gnt: 4'b0010, tap: 2'd1, lat: 48});
    sb.push_back('{gnt: 4'b0001, tap: 2'd0, lat: 48});
    wait_grant(lat);
    sb_check("hold_first", lat);
    wait_change(4'b0001, n);
    sb_check("hold_to1", n);
    wait_change(4'b0010, n);
    sb_check("hold_back0", n);

    // Owner with tap 3 releases mid-period: grant drops at once, clock finishes its period.
    do_reset();
    req     = 4'b0001;
    tap_sel = 8'h03;
    sb.push_back('{gnt: 4'b0001, tap: 2'd3, lat: 16});
    wait_grant(lat);
    sb_check("drain_grant", lat);
    wait_cnt(4'd6);
    req = '0;
    @(negedge CLK);
    check("drain_gnt", gnt, '0);
    check("drain_busy", busy, 1'b1);
    while (tb_cnt != 0) begin
      check("drain_div_clk", div_clk, tb_cnt[3]);
      @(negedge CLK);
    end
    check("drain_end", {gnt, div_clk, busy}, '0);
    @(negedge CLK);
    check("drain_idle", {div_clk, busy}, '0);

    // tap_sel change while owning is ignored.
    do_reset();
    req     = 4'b0001;
    tap_sel = 8'h01;
    sb.push_back('{gnt: 4'b0001, tap: 2'd1, lat: 16});
    wait_grant(lat);
    sb_check("tapfix_grant", lat);
    @(negedge CLK);
    tap_sel = 8'h03;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      check("tapfix_tap", active_tap, 2'd1);
      check("tapfix_div_clk", div_clk, tb_cnt[1]);
    end

    // Asynchronous reset while div_clk is high; rr pointer restarts at 0.
    do_reset();
    req     = 4'b0001;
    tap_sel = 8'h01;
    sb.push_back('{gnt: 4'b0001, tap: 2'd1, lat: 16});
    wait_grant(lat);
    sb_check("rst_grant", lat);
    n = 0;
    while (!div_clk && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check("rst_seen_high", div_clk, 1'b1);
    RESET = 1'b1;
    req   = 4'b0011;
    #1;
    check("rst_async", {gnt, div_clk, div_en, busy}, '0);
    @(negedge CLK);
    RESET = 1'b0;
    sb.push_back('{gnt: 4'b0001, tap: 2'd1, lat: 16});
    wait_grant(lat);
    sb_check("rst_rr", lat);

    // Owner 1 releases as requester 3 arrives: drain, then grant 3 at the wrap.
    do_reset();
    req     = 4'b0010;
    tap_sel = 8'h08;
    sb.push_back('{gnt: 4'b0010, tap: 2'd2, lat: 16});
    wait_grant(lat);
    sb_check("swap_first", lat);
    wait_cnt(4'd5);
    req = 4'b1000;
    sb.push_back('{gnt: 4'b1000, tap: 2'd0, lat: 11});
    @(negedge CLK);
    check("swap_drain_gnt", gnt, '0);
    check("swap_drain_busy", busy, 1'b1);
    wait_grant(lat);
    sb_check("swap_second", lat + 1);
    repeat (20) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
